// File: rtl/memory_router_pkg.sv
// Shared constants and types for the memory router: default address map,
// watchdog limit, FSM state encoding and the registered request payload.
package memory_router_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STRB_W   = 4;
    localparam int unsigned N_SLAVES = 3;

    // Bit positions inside the one-hot slave select
    localparam int unsigned SEL_ROM = 2;
    localparam int unsigned SEL_RAM = 1;
    localparam int unsigned SEL_IO  = 0;

    localparam logic [ADDR_W-1:0] DEF_ROM_BASE = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] DEF_ROM_MASK = 32'hFFFF_0000;
    localparam logic [ADDR_W-1:0] DEF_RAM_BASE = 32'h8000_0000;
    localparam logic [ADDR_W-1:0] DEF_RAM_MASK = 32'hFFF0_0000;
    localparam logic [ADDR_W-1:0] DEF_IO_BASE  = 32'h2000_0000;
    localparam logic [ADDR_W-1:0] DEF_IO_MASK  = 32'hFFFF_F000;

    localparam int unsigned DEF_TIMEOUT = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_e;

    typedef struct packed {
        logic              instr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } req_t;

    function automatic logic addr_hit(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] base,
                                      input logic [ADDR_W-1:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/memory_router_if.sv
// Simple valid/ready memory bus; master drives the request, slave answers.
interface memory_router_if;
    import memory_router_pkg::*;

    logic              valid;
    logic              instr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] rdata;
    logic              error;
    logic              ready;

    modport master (
        output valid, instr, addr, wdata, wstrb,
        input  rdata, error, ready
    );

    modport slave (
        input  valid, instr, addr, wdata, wstrb,
        output rdata, error, ready
    );

endinterface

// File: rtl/memory_router_decode.sv
// Address decoder: maps an upstream address/strobe onto a one-hot slave
// select, or flags a local error (unmapped address or write to ROM).
module router_decode
    import memory_router_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ROM_BASE = DEF_ROM_BASE,
    parameter logic [ADDR_W-1:0] ROM_MASK = DEF_ROM_MASK,
    parameter logic [ADDR_W-1:0] RAM_BASE = DEF_RAM_BASE,
    parameter logic [ADDR_W-1:0] RAM_MASK = DEF_RAM_MASK,
    parameter logic [ADDR_W-1:0] IO_BASE  = DEF_IO_BASE,
    parameter logic [ADDR_W-1:0] IO_MASK  = DEF_IO_MASK
) (
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [STRB_W-1:0]   wstrb_i,
    output logic [N_SLAVES-1:0] sel_c_o,
    output logic                err_c_o
);

    // Region priority on overlap is rom > ram > io
    always_comb begin
        sel_c_o = '0;
        err_c_o = 1'b0;
        if (addr_hit(addr_i, ROM_BASE, ROM_MASK)) begin
            if (wstrb_i != '0) err_c_o = 1'b1;
            else               sel_c_o[SEL_ROM] = 1'b1;
        end else if (addr_hit(addr_i, RAM_BASE, RAM_MASK)) begin
            sel_c_o[SEL_RAM] = 1'b1;
        end else if (addr_hit(addr_i, IO_BASE, IO_MASK)) begin
            sel_c_o[SEL_IO] = 1'b1;
        end else begin
            err_c_o = 1'b1;
        end
    end

endmodule

// File: rtl/memory_router.sv
// Routes the arbitrated memory port to boot ROM, RAM or I/O, returns the
// slave response, and answers decode errors and silent slaves locally.
module memory_router
    import memory_router_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ROM_BASE = DEF_ROM_BASE,
    parameter logic [ADDR_W-1:0] ROM_MASK = DEF_ROM_MASK,
    parameter logic [ADDR_W-1:0] RAM_BASE = DEF_RAM_BASE,
    parameter logic [ADDR_W-1:0] RAM_MASK = DEF_RAM_MASK,
    parameter logic [ADDR_W-1:0] IO_BASE  = DEF_IO_BASE,
    parameter logic [ADDR_W-1:0] IO_MASK  = DEF_IO_MASK,
    parameter int unsigned       TIMEOUT  = DEF_TIMEOUT
) (
    input  logic            clock,
    input  logic            reset,
    memory_router_if.slave  memory,
    memory_router_if.master rom,
    memory_router_if.master ram,
    memory_router_if.master io
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef struct packed {
        state_e              state;
        logic [N_SLAVES-1:0] sel;
        req_t                req;
        logic [CNT_W-1:0]    cnt;
    } regs_t;

    regs_t st_q, st_d;

    logic [N_SLAVES-1:0] dec_sel;
    logic                dec_err;
    logic [N_SLAVES-1:0] slv_ready;
    logic [DATA_W-1:0]   slv_rdata;
    logic                slv_error;
    logic                done_c;
    logic                accept_c;
    logic [DATA_W-1:0]   resp_rdata;
    logic                resp_error;
    logic                busy_c;
    logic [N_SLAVES-1:0] act_c;

    router_decode #(
        .ROM_BASE (ROM_BASE),
        .ROM_MASK (ROM_MASK),
        .RAM_BASE (RAM_BASE),
        .RAM_MASK (RAM_MASK),
        .IO_BASE  (IO_BASE),
        .IO_MASK  (IO_MASK)
    ) u_decode (
        .addr_i  (memory.addr),
        .wstrb_i (memory.wstrb),
        .sel_c_o (dec_sel),
        .err_c_o (dec_err)
    );

    // Response of the selected slave only; others are ignored
    always_comb begin
        slv_ready = {rom.ready, ram.ready, io.ready} & st_q.sel;
        slv_rdata = '0;
        slv_error = 1'b0;
        if (st_q.sel[SEL_ROM]) begin
            slv_rdata = rom.rdata;
            slv_error = rom.error;
        end
        if (st_q.sel[SEL_RAM]) begin
            slv_rdata = ram.rdata;
            slv_error = ram.error;
        end
        if (st_q.sel[SEL_IO]) begin
            slv_rdata = io.rdata;
            slv_error = io.error;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) st_q <= '0;
        else        st_q <= st_d;
    end

    // Completion, watchdog and back-to-back accept
    always_comb begin
        st_d       = st_q;
        done_c     = 1'b0;
        resp_rdata = '0;
        resp_error = 1'b0;
        unique case (st_q.state)
            BUSY: begin
                if (|slv_ready) begin
                    done_c     = 1'b1;
                    resp_rdata = slv_rdata;
                    resp_error = slv_error;
                end else if (st_q.cnt == CNT_LAST) begin
                    done_c     = 1'b1;
                    resp_error = 1'b1;
                end else begin
                    st_d.cnt = st_q.cnt + CNT_W'(1);
                end
            end
            ERR: begin
                done_c     = 1'b1;
                resp_error = 1'b1;
            end
            default: ;
        endcase

        accept_c = memory.valid && ((st_q.state == IDLE) || done_c);
        if (done_c) st_d.state = IDLE;
        if (accept_c) begin
            st_d.req.instr = memory.instr;
            st_d.req.addr  = memory.addr;
            st_d.req.wdata = memory.wdata;
            st_d.req.wstrb = memory.wstrb;
            st_d.sel       = dec_err ? '0 : dec_sel;
            st_d.cnt       = '0;
            st_d.state     = dec_err ? ERR : BUSY;
        end
    end

    // Outputs forced low while reset is sampled low
    assign memory.ready = reset & done_c;
    assign memory.error = reset & resp_error;
    assign memory.rdata = reset ? resp_rdata : '0;

    assign busy_c = reset && (st_q.state == BUSY);
    assign act_c  = busy_c ? st_q.sel : '0;

    assign rom.valid = act_c[SEL_ROM];
    assign rom.instr = act_c[SEL_ROM] & st_q.req.instr;
    assign rom.addr  = act_c[SEL_ROM] ? st_q.req.addr  : '0;
    assign rom.wdata = act_c[SEL_ROM] ? st_q.req.wdata : '0;
    assign rom.wstrb = act_c[SEL_ROM] ? st_q.req.wstrb : '0;

    assign ram.valid = act_c[SEL_RAM];
    assign ram.instr = act_c[SEL_RAM] & st_q.req.instr;
    assign ram.addr  = act_c[SEL_RAM] ? st_q.req.addr  : '0;
    assign ram.wdata = act_c[SEL_RAM] ? st_q.req.wdata : '0;
    assign ram.wstrb = act_c[SEL_RAM] ? st_q.req.wstrb : '0;

    assign io.valid  = act_c[SEL_IO];
    assign io.instr  = act_c[SEL_IO] & st_q.req.instr;
    assign io.addr   = act_c[SEL_IO] ? st_q.req.addr  : '0;
    assign io.wdata  = act_c[SEL_IO] ? st_q.req.wdata : '0;
    assign io.wstrb  = act_c[SEL_IO] ? st_q.req.wstrb : '0;

endmodule

// File: tb/tb_memory_router.sv
// Bench for memory_router: directed and random transactions checked per
// cycle against a transaction-level model of the address map and watchdog.
module tb_memory_router;

    localparam int unsigned TMO = 8;

    localparam logic [31:0] ROM_B = 32'h0000_0000, ROM_M = 32'hFFFF_0000;
    localparam logic [31:0] RAM_B = 32'h8000_0000, RAM_M = 32'hFFF0_0000;
    localparam logic [31:0] IO_B  = 32'h2000_0000, IO_M  = 32'hFFFF_F000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
        int          k;       // slave ready k cycles after accept; 0 = never
        logic [31:0] srdata;
        logic        serr;
        int          gap;     // idle cycles after completion; 0 = back-to-back
    } txn_t;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;
    txn_t txq[$];

    memory_router_if mem_if ();
    memory_router_if rom_if ();
    memory_router_if ram_if ();
    memory_router_if io_if ();

    memory_router #(.TIMEOUT(TMO)) dut (
        .clock  (clock),
        .reset  (reset),
        .memory (mem_if),
        .rom    (rom_if),
        .ram    (ram_if),
        .io     (io_if)
    );

    logic [69:0] rom_req, ram_req, io_req;
    assign rom_req = {rom_if.valid, rom_if.instr, rom_if.addr, rom_if.wdata, rom_if.wstrb};
    assign ram_req = {ram_if.valid, ram_if.instr, ram_if.addr, ram_if.wdata, ram_if.wstrb};
    assign io_req  = {io_if.valid, io_if.instr, io_if.addr, io_if.wdata, io_if.wstrb};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Target slave from the address map: 0 = local error, 1 rom, 2 ram, 3 io
    function automatic int tgt_of(input txn_t t);
        if ((t.addr & ROM_M) == ROM_B) return (t.wstrb == 4'h0) ? 1 : 0;
        if ((t.addr & RAM_M) == RAM_B) return 2;
        if ((t.addr & IO_M) == IO_B) return 3;
        return 0;
    endfunction

    function automatic txn_t mk(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                                input logic in, input int k, input logic [31:0] rd,
                                input logic se, input int gap);
        txn_t t;
        t.addr = a; t.wdata = wd; t.wstrb = ws; t.instr = in;
        t.k = k; t.srdata = rd; t.serr = se; t.gap = gap;
        return t;
    endfunction

    task automatic present(input txn_t t);
        mem_if.valid = 1'b1;
        mem_if.instr = t.instr;
        mem_if.addr  = t.addr;
        mem_if.wdata = t.wdata;
        mem_if.wstrb = t.wstrb;
    endtask

    task automatic idle_bus();
        mem_if.valid = 1'b0;
        mem_if.instr = 1'($urandom);
        mem_if.addr  = $urandom;
        mem_if.wdata = $urandom;
        mem_if.wstrb = 4'($urandom);
    endtask

    // Target answers exactly at cycle k; every other slave sends random noise
    task automatic drive_slaves(input int tgt, input int j, input txn_t t);
        rom_if.ready = (tgt == 1) ? (j == t.k) : 1'($urandom);
        rom_if.rdata = (tgt == 1) ? t.srdata : $urandom;
        rom_if.error = (tgt == 1) ? t.serr : 1'($urandom);
        ram_if.ready = (tgt == 2) ? (j == t.k) : 1'($urandom);
        ram_if.rdata = (tgt == 2) ? t.srdata : $urandom;
        ram_if.error = (tgt == 2) ? t.serr : 1'($urandom);
        io_if.ready  = (tgt == 3) ? (j == t.k) : 1'($urandom);
        io_if.rdata  = (tgt == 3) ? t.srdata : $urandom;
        io_if.error  = (tgt == 3) ? t.serr : 1'($urandom);
    endtask

    task automatic check_slaves(input int tgt, input txn_t t, input string tag);
        logic [69:0] full;
        full = {1'b1, t.instr, t.addr, t.wdata, t.wstrb};
        check({tag, "_rom"}, rom_req, (tgt == 1) ? full : 70'h0);
        check({tag, "_ram"}, ram_req, (tgt == 2) ? full : 70'h0);
        check({tag, "_io"},  io_req,  (tgt == 3) ? full : 70'h0);
    endtask

    task automatic check_resp(input string tag, input logic [33:0] exp);
        check(tag, 70'({mem_if.ready, mem_if.error, mem_if.rdata}), 70'(exp));
    endtask

    task automatic run_seq();
        bit          pre;
        int          tgt;
        int          c;
        logic [33:0] resp_exp;
        txn_t        t;
        pre = 1'b0;
        for (int i = 0; i < txq.size(); i++) begin
            t   = txq[i];
            tgt = tgt_of(t);
            if (tgt == 0)                         c = 1;
            else if (t.k >= 1 && t.k <= int'(TMO)) c = t.k;
            else                                  c = int'(TMO);
            if (tgt != 0 && c == t.k) resp_exp = {1'b1, t.serr, t.srdata};
            else                      resp_exp = {2'b11, 32'h0};
            if (!pre) begin
                @(negedge clock);
                present(t);
                drive_slaves(0, 0, t);
                #1;
                check_resp($sformatf("idle_resp[%0d]", i), 34'h0);
            end
            for (int j = 1; j <= c; j++) begin
                @(negedge clock);
                drive_slaves(tgt, j, t);
                if (j == c) begin
                    pre = (t.gap == 0) && (i + 1 < txq.size());
                    if (pre) present(txq[i+1]);
                    else     idle_bus();
                end
                #1;
                check_resp($sformatf("resp[%0d.%0d]", i, j), (j == c) ? resp_exp : 34'h0);
                check_slaves(tgt, t, $sformatf("req[%0d.%0d]", i, j));
            end
            for (int g = 0; g < t.gap; g++) begin
                @(negedge clock);
                idle_bus();
                drive_slaves(0, 0, t);
                #1;
                check_resp($sformatf("gap_resp[%0d.%0d]", i, g), 34'h0);
                check_slaves(0, t, $sformatf("gap[%0d.%0d]", i, g));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        txn_t t;
        int   cls;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        t        = mk(32'h0, 32'h0, 4'h0, 1'b0, 0, 32'h0, 1'b0, 0);
        idle_bus();
        drive_slaves(0, 0, t);

        // Reset state: every output low
        repeat (2) begin
            @(negedge clock);
            drive_slaves(0, 0, t);
            #1;
            check_resp("reset_resp", 34'h0);
            check_slaves(0, t, "reset");
        end
        @(negedge clock);
        reset = 1'b1;

        // Directed cases
        txq.push_back(mk(32'h0000_0010, 32'h0, 4'h0, 1'b0, 3, 32'hDEAD_BEEF, 1'b0, 2));
        txq.push_back(mk(32'h8000_0004, 32'h1234_5678, 4'hF, 1'b0, 1, 32'h0, 1'b0, 1));
        txq.push_back(mk(32'h4000_0000, 32'h0, 4'h0, 1'b0, 1, 32'h0, 1'b0, 1));
        txq.push_back(mk(32'h0000_0000, 32'hFFFF_FFFF, 4'h1, 1'b0, 1, 32'h0, 1'b0, 1));
        txq.push_back(mk(32'h2000_0010, 32'h0, 4'h0, 1'b0, 0, 32'h0, 1'b0, 1));
        txq.push_back(mk(32'h2000_0020, 32'h0, 4'h0, 1'b0, 8, 32'hCAFE_F00D, 1'b0, 1));
        txq.push_back(mk(32'h8000_0100, 32'h0, 4'h0, 1'b0, 2, 32'h1111_2222, 1'b0, 0));
        txq.push_back(mk(32'h0000_0020, 32'h0, 4'h0, 1'b1, 1, 32'h3333_4444, 1'b0, 0));
        txq.push_back(mk(32'h2000_0FFC, 32'hABCD_0123, 4'h3, 1'b0, 4, 32'h5555_6666, 1'b1, 1));
        run_seq();

        // Random traffic
        txq.delete();
        for (int n = 0; n < 40; n++) begin
            cls = $urandom_range(0, 3);
            case (cls)
                0:       t.addr = {16'h0000, 16'($urandom)};
                1:       t.addr = {12'h800, 20'($urandom)};
                2:       t.addr = {20'h20000, 12'($urandom)};
                default: t.addr = $urandom;
            endcase
            t.wstrb  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            t.wdata  = $urandom;
            t.instr  = 1'($urandom);
            t.k      = $urandom_range(0, TMO + 2);
            t.srdata = $urandom;
            t.serr   = 1'($urandom);
            t.gap    = $urandom_range(0, 2);
            txq.push_back(t);
        end
        run_seq();

        // Reset while an I/O access is outstanding
        t = mk(32'h2000_0004, 32'h0, 4'h0, 1'b0, 0, 32'h0, 1'b0, 0);
        @(negedge clock);
        present(t);
        drive_slaves(0, 0, t);
        repeat (3) begin
            @(negedge clock);
            drive_slaves(3, 1, t);
            #1;
            check_slaves(3, t, "pre_reset");
        end
        @(negedge clock);
        reset        = 1'b0;
        io_if.ready  = 1'b1;
        io_if.rdata  = 32'hA5A5_A5A5;
        io_if.error  = 1'b1;
        #1;
        check_resp("midreset_resp", 34'h0);
        check_slaves(0, t, "midreset");
        @(negedge clock);
        reset = 1'b1;
        idle_bus();
        drive_slaves(0, 0, t);
        #1;
        check_resp("post_reset_resp", 34'h0);
        check_slaves(0, t, "post_reset");

        txq.delete();
        txq.push_back(mk(32'h8000_0040, 32'h0, 4'h0, 1'b0, 2, 32'h7777_8888, 1'b0, 1));
        run_seq();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_router.md
# memory_router

Address-decoding router between the single arbitrated memory port and three memory-mapped slaves: boot ROM, RAM and I/O. It registers each accepted request, forwards it to the decoded slave and returns that slave's response upstream. Unmapped addresses and ROM writes get a local error response. A watchdog turns a silent slave into an error. Sits directly downstream of the instruction/data arbiter.

## Interface
- ROM_BASE, 32'h0000_0000, ROM match value; ROM_MASK, 32'hFFFF_0000
- RAM_BASE, 32'h8000_0000, RAM match value; RAM_MASK, 32'hFFF0_0000
- IO_BASE, 32'h2000_0000, I/O match value; IO_MASK, 32'hFFFF_F000
- TIMEOUT, 256, slave response limit in cycles, ≥2
- clock  in  1  clock
- reset  in  1  synchronous, active-low
- memory_valid / memory_instr  in  1 / 1  upstream request, level-held until memory_ready; instruction-fetch flag
- memory_addr / memory_wdata / memory_wstrb  in  32 / 32 / 4  upstream request; wstrb 0 = read
- memory_rdata / memory_error / memory_ready  out  32 / 1 / 1  upstream response
- x_valid, x_instr  out  1, 1  slave request, x ∈ {rom, ram, io}
- x_addr, x_wdata, x_wstrb  out  32, 32, 4  slave request fields
- x_rdata, x_error, x_ready  in  32, 1, 1  slave response

## Operation
- States: IDLE, BUSY, ERR.
- Accept: memory_valid=1 in IDLE, or in a completion cycle of BUSY/ERR (back-to-back). On accept, register instr/addr/wdata/wstrb, decode, clear counter.
- Decode: hit when (addr & MASK) == BASE. Priority on overlap: rom > ram > io.
- Error decode: no hit, or ROM hit with wstrb≠0. Next state is ERR; no slave sees the request.
- Otherwise next state is BUSY with the one-hot select registered.
- BUSY: only the selected slave's x_valid is 1. Its fields come from the request register and are held constant until completion. Other slaves' outputs are all 0.
- BUSY completion, selected x_ready=1: memory_ready=1, memory_rdata/memory_error = slave values. This wins over a same-cycle timeout.
- BUSY timeout: counter == TIMEOUT-1 with no ready gives memory_ready=1, memory_error=1, memory_rdata=0. x_valid drops next cycle.
- The counter increments every BUSY cycle without ready and saturates; no wrap.
- ERR: memory_ready=1, memory_error=1, memory_rdata=0 for exactly one cycle.
- After completion: next state is IDLE unless a new accept happens in the same cycle.
- memory_valid while BUSY/ERR (not completing) is ignored; upstream holds the request.
- x_ready from unselected slaves, or any x_ready in IDLE, is ignored.
- memory_rdata/error are 0 whenever memory_ready=0.

## Timing
- Reset (any time, including mid-transaction): state IDLE, counter 0, select cleared, request register 0. All outputs 0 in the same cycle reset is sampled low. A slave left mid-access is abandoned.
- Latency: accept at cycle T gives x_valid at T+1. A slave ready at T+k gives memory_ready at T+k, combinational from x_ready/x_rdata/x_error.
- Decode error: memory_ready at T+1.
- Timeout: memory_ready at T+TIMEOUT when no ready arrives.
- Back-to-back: a new request accepted in completion cycle T+k reaches its slave at T+k+1; no idle bubble.
- x_valid is level, high from T+1 through the completion cycle inclusive.

## Structure
- Shared constants package: state typedef (IDLE/BUSY/ERR), default map bases and masks, default TIMEOUT.
- Sub-module router_decode: combinational address plus wstrb to one-hot {rom, ram, io} and err. Instantiated once on the upstream inputs.
- Top holds a single registered state struct and one combinational next-state block.

## Test plan
- Read 0x0000_0010, rom_ready after 3 cycles with rdata 0xDEADBEEF → rom_valid T+1..T+3, memory_ready T+3, rdata 0xDEADBEEF, error 0.
- Write 0x8000_0004, wstrb 4'hF, wdata 0x1234_5678 → ram_valid with wstrb 4'hF/wdata 0x12345678 at T+1; ram_ready 1 cycle later → memory_ready, error 0.
- Read 0x4000_0000 (unmapped), and write 0x0000_0000 with wstrb 4'h1 → memory_ready=1, error=1, rdata 0 at T+1; no x_valid asserted.
- io read, io_ready never asserted, TIMEOUT=8 → error response at T+8, io_valid low at T+9. Variant with io_ready exactly at T+8 → slave response, error 0.
- Back-to-back: memory_valid held high, RAM read then ROM read → ROM request accepted in the RAM completion cycle, rom_valid the next cycle.
- Reset low while BUSY on io → all outputs 0 that cycle; after release, the next read to RAM completes normally.
